// File: rtl/crt_dot_raster_if.sv
// Video bundle for crt_dot_raster.
// It carries timing-generator inputs, the store read port and the aligned pixel outputs.
// master: timing generator + store side.  slave: the renderer.
interface crt_dot_raster_if #(
    parameter int unsigned COLS  = 32,
    parameter int unsigned ROWS  = 32,
    parameter int unsigned POS_W = 11
);
    logic                    de_in;
    logic                    hs_in;
    logic                    vs_in;
    logic [POS_W-1:0]        hpos;
    logic [POS_W-1:0]        vpos;
    logic [$clog2(ROWS)-1:0] mem_addr;
    logic [COLS-1:0]         mem_data;
    logic                    pixel;
    logic                    de_out;
    logic                    hs_out;
    logic                    vs_out;

    modport master (
        output de_in, hs_in, vs_in, hpos, vpos, mem_data,
        input  mem_addr, pixel, de_out, hs_out, vs_out
    );

    modport slave (
        input  de_in, hs_in, vs_in, hpos, vpos, mem_data,
        output mem_addr, pixel, de_out, hs_out, vs_out
    );
endinterface

// File: rtl/crt_dot_raster.sv
// CRT store raster renderer: draws each store bit as a procedural dot/dash or block glyph.
// Three-stage pipeline (position decode, store bit + glyph, pixel register) with sync/de
// delayed to match.
// Optional feature macro: CRT_RASTER_BLINK_EN blinks the line selected by i_hl_row.
module crt_dot_raster #(
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 32,
    parameter int unsigned CELL_W       = 16,
    parameter int unsigned CELL_H       = 16,
    parameter int unsigned X0           = 64,
    parameter int unsigned Y0           = 32,
    parameter int unsigned POS_W        = 11,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_mode,
    input  logic [$clog2(ROWS)-1:0] i_hl_row,
    crt_dot_raster_if.slave         io_vid
);
    localparam int unsigned AW     = $clog2(ROWS);
    localparam int unsigned CLW    = $clog2(COLS);
    localparam int unsigned CXW    = $clog2(CELL_W);
    localparam int unsigned CYW    = $clog2(CELL_H);
    localparam int unsigned GRID_W = COLS * CELL_W;
    localparam int unsigned GRID_H = ROWS * CELL_H;

    // Stage 0 (combinational) decode
    logic [POS_W-1:0] w_dx;
    logic [POS_W-1:0] w_dy;
    logic [AW-1:0]    w_row;
    logic             w_in_grid;
    logic             w_blank;

    // Stage 1 / stage 2 registers
    logic             r_s1_in, r_s1_mode, r_s1_blank;
    logic [CXW-1:0]   r_s1_cx;
    logic [CYW-1:0]   r_s1_cy;
    logic [CLW-1:0]   r_s1_col;
    logic [AW-1:0]    r_mem_addr;
    logic             r_s2_in, r_s2_mode, r_s2_blank;
    logic [CXW-1:0]   r_s2_cx;
    logic [CYW-1:0]   r_s2_cy;
    logic [CLW-1:0]   r_s2_col;
    logic             r_pixel;
    logic [2:0]       r_de_dly, r_hs_dly, r_vs_dly;

    // Glyph evaluation
    logic             w_bit, w_band, w_dash, w_dot, w_block, w_glyph, w_pixel_d;
    logic [31:0]      w_cx, w_cy;

    // Decode position into region flag and cell coordinates; region test done in 32 bits
    // so positions left of / above the grid are never wrapped into it.
    always_comb begin
        w_dx      = io_vid.hpos - POS_W'(X0);
        w_dy      = io_vid.vpos - POS_W'(Y0);
        w_row     = AW'(w_dy >> CYW);
        w_in_grid = io_vid.de_in
                    && (32'(io_vid.hpos) >= X0) && (32'(io_vid.hpos) < X0 + GRID_W)
                    && (32'(io_vid.vpos) >= Y0) && (32'(io_vid.vpos) < Y0 + GRID_H);
    end

`ifdef CRT_RASTER_BLINK_EN
    localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);

    logic [FW-1:0] r_frame;
    logic          r_vs_prev;

    // Frame counter advanced on each vsync rising edge, wrapping after two half-periods
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame   <= '0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= io_vid.vs_in;
            if (io_vid.vs_in && !r_vs_prev) begin
                r_frame <= (r_frame == FW'(2 * BLINK_FRAMES - 1)) ? '0 : r_frame + FW'(1);
            end
        end
    end

    assign w_blank = (w_row == i_hl_row) && (32'(r_frame) >= BLINK_FRAMES);
`else
    logic w_unused_hl_row;

    assign w_blank         = 1'b0;
    assign w_unused_hl_row = ^i_hl_row;
`endif

    // Stage 1: register decoded position and issue the store read for this line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_in    <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s1_cx    <= '0;
            r_s1_cy    <= '0;
            r_s1_col   <= '0;
            r_mem_addr <= '0;
        end else begin
            r_s1_in    <= w_in_grid;
            r_s1_mode  <= i_mode;
            r_s1_blank <= w_blank;
            r_s1_cx    <= CXW'(w_dx);
            r_s1_cy    <= CYW'(w_dy);
            r_s1_col   <= CLW'(w_dx >> CXW);
            r_mem_addr <= w_row;
        end
    end

    // Stage 2: carry cell state alongside the one-cycle store read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_in    <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_blank <= 1'b0;
            r_s2_cx    <= '0;
            r_s2_cy    <= '0;
            r_s2_col   <= '0;
        end else begin
            r_s2_in    <= r_s1_in;
            r_s2_mode  <= r_s1_mode;
            r_s2_blank <= r_s1_blank;
            r_s2_cx    <= r_s1_cx;
            r_s2_cy    <= r_s1_cy;
            r_s2_col   <= r_s1_col;
        end
    end

    // Select the store bit (col 0 = LSB) and evaluate the procedural glyph
    always_comb begin
        w_bit   = io_vid.mem_data[r_s2_col];
        w_cx    = 32'(r_s2_cx);
        w_cy    = 32'(r_s2_cy);
        w_band  = (w_cy >= CELL_H / 2 - 2) && (w_cy <= CELL_H / 2 + 1);
        w_dash  = w_band && (w_cx >= 1) && (w_cx <= CELL_W - 2);
        w_dot   = w_band && (w_cx >= CELL_W / 2 - 2) && (w_cx <= CELL_W / 2 + 1);
        w_block = (w_cy >= 2) && (w_cy <= CELL_H - 3) && (w_cx >= 2) && (w_cx <= CELL_W - 3);
        if (r_s2_mode) begin
            w_glyph = w_bit && w_block;
        end else begin
            w_glyph = w_bit ? w_dash : w_dot;
        end
        w_pixel_d = r_s2_in && !r_s2_blank && w_glyph;
    end

    // Stage 3: pixel register plus matching three-deep sync/enable delay
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pixel  <= 1'b0;
            r_de_dly <= '0;
            r_hs_dly <= '0;
            r_vs_dly <= '0;
        end else begin
            r_pixel  <= w_pixel_d;
            r_de_dly <= {r_de_dly[1:0], io_vid.de_in};
            r_hs_dly <= {r_hs_dly[1:0], io_vid.hs_in};
            r_vs_dly <= {r_vs_dly[1:0], io_vid.vs_in};
        end
    end

    assign io_vid.mem_addr = r_mem_addr;
    assign io_vid.pixel    = r_pixel;
    assign io_vid.de_out   = r_de_dly[2];
    assign io_vid.hs_out   = r_hs_dly[2];
    assign io_vid.vs_out   = r_vs_dly[2];
endmodule

// File: tb/tb_crt_dot_raster.sv
// Self-checking bench for crt_dot_raster: directed glyph/boundary/reset/blink cases with
// literal expectations, then randomized positions checked against a behavioural model.
module tb_crt_dot_raster;
    localparam int COLS   = 32;
    localparam int ROWS   = 32;
    localparam int CELL_W = 16;
    localparam int CELL_H = 16;
    localparam int X0     = 64;
    localparam int Y0     = 32;
    localparam int POS_W  = 11;
    localparam int BF     = 2;
    localparam int HL     = 5;

    typedef struct {
        bit pix;
        bit de;
        bit hs;
        bit vs;
        int lit;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       mode_r;
    logic [4:0] hl_row;
    logic [COLS-1:0] store [ROWS];

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_cnt = 0;
    bit   vs_prev   = 0;

    crt_dot_raster_if #(.COLS(COLS), .ROWS(ROWS), .POS_W(POS_W)) vid ();

    crt_dot_raster #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .X0(X0), .Y0(Y0), .POS_W(POS_W), .BLINK_FRAMES(BF)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_mode  (mode_r),
        .i_hl_row(hl_row),
        .io_vid  (vid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store with a one-cycle synchronous read
    always @(posedge clk) vid.mem_data <= store[vid.mem_addr];

    // What the pixel must be for a position, from the glyph rules
    function automatic bit model_pix(int h, int v, bit d, bit md, bit ph);
        int col, row, cx, cy;
        bit b, band, on;
        if (!d || h < X0 || h >= X0 + COLS * CELL_W || v < Y0 || v >= Y0 + ROWS * CELL_H)
            return 1'b0;
        col  = (h - X0) / CELL_W;
        cx   = (h - X0) % CELL_W;
        row  = (v - Y0) / CELL_H;
        cy   = (v - Y0) % CELL_H;
        b    = store[row][col];
        band = (cy >= CELL_H / 2 - 2) && (cy <= CELL_H / 2 + 1);
        if (!md) begin
            if (b) on = band && cx >= 1 && cx <= CELL_W - 2;
            else   on = band && cx >= CELL_W / 2 - 2 && cx <= CELL_W / 2 + 1;
        end else begin
            on = b && cy >= 2 && cy <= CELL_H - 3 && cx >= 2 && cx <= CELL_W - 3;
        end
`ifdef CRT_RASTER_BLINK_EN
        if (ph && row == HL) on = 1'b0;
`else
        if (ph) on = on;
`endif
        return on;
    endfunction

    // Drive one pixel slot and queue what must emerge three clocks later
    task automatic drive(input int h, input int v, input bit d, input bit hs, input bit vs,
                         input bit md, input bit rst, input int lit);
        exp_t e;
        exp_t z;
        @(negedge clk);
        vid.hpos  = POS_W'(h);
        vid.vpos  = POS_W'(v);
        vid.de_in = d;
        vid.hs_in = hs;
        vid.vs_in = vs;
        mode_r    = md;
        reset     = rst;
        z = '{pix: 0, de: 0, hs: 0, vs: 0, lit: -1};
        if (rst) begin
            // reset flushes everything still in flight
            for (int k = 0; k < 2; k++) begin
                if (q.size() > k) q[q.size() - 1 - k] = z;
            end
            q.push_back(z);
            frame_cnt = 0;
            vs_prev   = 0;
        end else begin
            e.pix = model_pix(h, v, d, md, frame_cnt >= BF);
            e.de  = d;
            e.hs  = hs;
            e.vs  = vs;
            e.lit = lit;
            q.push_back(e);
            if (vs && !vs_prev) frame_cnt = (frame_cnt + 1) % (2 * BF);
            vs_prev = vs;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, mode_r, 0, -1);
    endtask

    task automatic fill(input logic [COLS-1:0] w);
        for (int r = 0; r < ROWS; r++) store[r] = w;
    endtask

    // Compare process: check DUT against the queued expectation every clock
    bit   rst_s;
    exp_t ce;
    always @(posedge clk) begin
        rst_s = reset;
        #1;
        if (rst_s) begin
            n_checks++;
            if (vid.mem_addr == 5'd0) n_pass++;
            else $display("FAIL mem_addr_reset: got %0d want 0", vid.mem_addr);
        end
        if (q.size() >= 3) begin
            ce = q.pop_front();
            n_checks++;
            if ({vid.pixel, vid.de_out, vid.hs_out, vid.vs_out} === {ce.pix, ce.de, ce.hs, ce.vs})
                n_pass++;
            else
                $display("FAIL outputs t=%0t: got pix/de/hs/vs=%b%b%b%b want %b%b%b%b", $time,
                         vid.pixel, vid.de_out, vid.hs_out, vid.vs_out,
                         ce.pix, ce.de, ce.hs, ce.vs);
            if (ce.lit >= 0) begin
                n_checks++;
                if (vid.pixel === ce.lit[0]) n_pass++;
                else $display("FAIL literal_pixel t=%0t: got %b want %0d", $time, vid.pixel,
                              ce.lit);
            end
        end
    end

    initial begin
        int lit;
        logic [COLS-1:0] w;
        hl_row = 5'(HL);
        mode_r = 1'b0;
        reset  = 1'b1;
        vid.de_in = 0; vid.hs_in = 0; vid.vs_in = 0; vid.hpos = '0; vid.vpos = '0;
        fill('1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, -1);

        // All-ones store, mode 0: cell (0,0) is a dash in rows 6..9, cx 1..14
        for (int cy = 0; cy < CELL_H; cy++)
            for (int cx = 0; cx < CELL_W; cx++) begin
                lit = (cy >= 6 && cy <= 9 && cx >= 1 && cx <= 14) ? 1 : 0;
                drive(X0 + cx, Y0 + cy, 1, cx[0], cy[0], 0, 0, lit);
            end

        // 32'h1: col 0 dash, col 1 dot
        idle(3);
        fill(32'h1);
        for (int cx = 0; cx < 2 * CELL_W; cx++) begin
            if (cx < CELL_W) lit = (cx >= 1 && cx <= 14) ? 1 : 0;
            else             lit = (cx - CELL_W >= 6 && cx - CELL_W <= 9) ? 1 : 0;
            drive(X0 + cx, Y0 + 7, 1, 0, 0, 0, 0, lit);
        end

        // Mode 1, alternating bits: odd cols are blocks, even cols blank, plus edges
        idle(3);
        fill(32'hAAAA_AAAA);
        for (int cy = 0; cy < CELL_H; cy++)
            for (int cx = 0; cx < 2 * CELL_W; cx++) begin
                lit = (cx >= CELL_W && cy >= 2 && cy <= 13 && cx - CELL_W >= 2
                       && cx - CELL_W <= 13) ? 1 : 0;
                drive(X0 + cx, Y0 + CELL_H + cy, 1, 0, 0, 1, 0, lit);
            end
        drive(X0 - 1,   Y0 + 5, 1, 0, 0, 1, 0, 0);
        drive(X0 + 512, Y0 + 5, 1, 0, 0, 1, 0, 0);
        drive(X0 + 509, Y0 + 5, 1, 0, 0, 1, 0, 1);
        drive(X0 + 511, Y0 + 5, 1, 0, 0, 1, 0, 0);
        drive(5,        Y0 + 5, 1, 0, 0, 1, 0, 0);

        // Reset in the middle of a dash run on row 3
        idle(3);
        fill('1);
        for (int cx = 1; cx <= 6; cx++) drive(X0 + cx, Y0 + 48 + 7, 1, 1, 1, 0, 0, 1);
        drive(X0 + 7, Y0 + 48 + 7, 1, 1, 1, 0, 1, -1);
        for (int cx = 8; cx <= 14; cx++) drive(X0 + cx, Y0 + 48 + 7, 1, 1, 0, 0, 0, 1);

        // Blink: row 5 dims in frames 2-3 only when the feature is built
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 1, -1);
        for (int f = 0; f <= 4; f++) begin
`ifdef CRT_RASTER_BLINK_EN
            lit = (f == 2 || f == 3) ? 0 : 1;
`else
            lit = 1;
`endif
            drive(X0 + 48 + 5, Y0 + 80 + 7, 1, 0, 0, 0, 0, lit);
            drive(X0 + 48 + 5, Y0 + 64 + 7, 1, 0, 0, 0, 0, 1);
            drive(0, 0, 0, 0, 1, 0, 0, -1);
            drive(0, 0, 0, 0, 1, 0, 0, -1);
            drive(0, 0, 0, 0, 0, 0, 0, -1);
        end

        // Randomized positions, stores, modes, syncs and occasional resets
        for (int seg = 0; seg < 30; seg++) begin
            idle(3);
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 3))
                    0:       w = '1;
                    1:       w = 32'hAAAA_AAAA;
                    default: w = $urandom;
                endcase
                store[r] = w;
            end
            for (int i = 0; i < 150; i++)
                drive($urandom_range(0, X0 + COLS * CELL_W + 40),
                      $urandom_range(0, Y0 + ROWS * CELL_H + 40),
                      ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                      ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                      ($urandom_range(0, 149) == 0), -1);
        end

        idle(6);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/crt_dot_raster.md
# crt_dot_raster

Parametrised CRT-store raster renderer for the Baby display path. It takes the display timing generator's pixel position and reads one store word per cell row. It then draws each store bit as a procedurally generated dot or dash glyph in a CELL_W × CELL_H cell, and emits a pixel aligned with delayed sync/enable. It replaces fixed per-glyph bit-mask ROMs, and adds selectable glyph modes and optional blinking of a highlighted line.

## Interface
- COLS, 32: bits per store word / glyph columns.
- ROWS, 32: store lines / glyph rows.
- CELL_W, 16: cell width in pixels; power of two, ≥8.
- CELL_H, 16: cell height in pixels; power of two, ≥8.
- X0, 64: left pixel of grid.
- Y0, 32: top line of grid.
- POS_W, 11: width of hpos/vpos.
- BLINK_FRAMES, 32: half-period of the highlight blink, in frames.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- de_in  in  1  active-video enable from timing generator.
- hs_in, vs_in  in  1 each  sync from timing generator; active-high.
- hpos, vpos  in  POS_W each  current pixel position.
- mode  in  1  0 = dot/dash (bit 1 dash, bit 0 dot); 1 = block (bit 1 block, bit 0 blank).
- hl_row  in  $clog2(ROWS)  line to blink.
- mem_addr  out  $clog2(ROWS)  store line address; registered.
- mem_data  in  COLS  store word; valid one cycle after mem_addr.
- pixel  out  1  glyph pixel.
- de_out, hs_out, vs_out  out  1 each  inputs delayed to align with pixel.

## Operation
- Grid region: X0 ≤ hpos < X0+COLS·CELL_W and Y0 ≤ vpos < Y0+ROWS·CELL_H, with de_in=1. Outside the region, pixel=0.
- Cell coordinates:
  - col = (hpos−X0)>>log2(CELL_W); row = (vpos−Y0)>>log2(CELL_H).
  - cx and cy are the low bits of the offsets.
  - Subtraction is POS_W wide. Values below X0/Y0 fail the region test and are never wrapped into the grid.
- Bit select: col 0 maps to mem_data[0] (LSB leftmost, Baby convention).
- Glyph geometry, inclusive ranges; band rows = CELL_H/2−2 .. CELL_H/2+1.
  - mode 0, bit 1: band rows, cx 1..CELL_W−2.
  - mode 0, bit 0: band rows, cx CELL_W/2−2 .. CELL_W/2+1.
  - mode 1, bit 1: cy 2..CELL_H−3, cx 2..CELL_W−3.
  - mode 1, bit 0: nothing drawn.
- mode is sampled in stage 1. A change mid-frame takes effect on the next pixel.
- Pipeline:
  - S1 registers region flag, cx, cy, col, row, and mem_addr=row.
  - S2 uses mem_data to select the bit and evaluate the glyph.
  - S3 registers pixel.
  - Sync and de pass through three matching registers.
- Frame counter: increments on the vs_in rising edge. It wraps from BLINK_FRAMES·2−1 to 0. blink_phase = counter ≥ BLINK_FRAMES.

## Timing
- Latency: 3 clk from hpos/vpos/de_in/hs_in/vs_in to pixel/de_out/hs_out/vs_out. Throughput is 1 pixel per clk.
- The memory read must complete in exactly 1 clk. No stall or handshake exists, because the display cannot wait.
- Reset behaviour:
  - While reset is high, every pipeline register clears: pixel, de_out, hs_out, vs_out and mem_addr are 0, and the frame counter is 0.
  - Reset mid-frame produces no partial glyph; outputs are 0 until valid data reaches S3.
  - The first valid output appears 3 clk after reset falls.
- Last cell boundary: hpos = X0+COLS·CELL_W−1 is in the grid; the next pixel is 0.
- Simultaneous vs rising edge and reset: reset wins and the counter becomes 0.

## Configuration
- CRT_RASTER_BLINK_EN defined:
  - When row == hl_row and blink_phase = 1, pixel is forced to 0 for that whole line's cells.
  - Otherwise, normal rendering.
- CRT_RASTER_BLINK_EN undefined:
  - No frame counter is built and hl_row is ignored.
  - Output is identical to the defined build with blink_phase permanently 0.

## Test plan
- Reset, then all-ones store, mode 0: a cell at (col 0, row 0) shows pixel=1 only for cy 6..9, cx 1..14, exactly 3 clk after the inputs; de/hs/vs are delayed 3 clk.
- mem_data=32'h1, mode 0: col 0 renders a dash (cx 1..14) and col 1 renders a dot (cx 6..9 only).
- mode 1, alternating 32'hAAAAAAAA: even cols blank; odd cols pixel=1 for cy 2..13, cx 2..13; hpos = X0−1 and hpos = X0+512 give 0.
- Assert reset mid-line with pixel=1: pixel, de_out, hs_out, vs_out and mem_addr read 0 on the next clk; the rendered stream resumes 3 clk after release.
- With CRT_RASTER_BLINK_EN, hl_row=5, BLINK_FRAMES=2: row 5 visible in frames 0–1, blank in frames 2–3, visible in frame 4; other rows are unaffected.
- With the macro undefined, the same stimulus shows row 5 visible in every frame.
